// File: rtl/axi3_read_mem_responder.sv
// axi3_read_mem_responder
//   Simulation-side AXI3 read slave. AR requests are queued with a timestamp,
//   held back until LATENCY cycles have elapsed, then replayed beat by beat
//   through a 1-cycle-latency memory read port into a 2-entry R output FIFO.
//
// Ports
//   CLK, reset            clock, asynchronous active-high reset
//   AR* (ARADDR..ARBURST) read address channel (slave side)
//   R*  (RDATA..RREADY)   read data channel (slave side)
//   mem_ren / mem_raddr   memory read strobe and 8-byte-aligned address
//   mem_rdata             data for the previous cycle's mem_ren
module axi3_read_mem_responder #(
   parameter int unsigned QDEPTH  = 4,
   parameter int unsigned LATENCY = 8
) (
   input  logic        CLK,
   input  logic        reset,
   input  logic [31:0] ARADDR,
   input  logic        ARVALID,
   output logic        ARREADY,
   input  logic [11:0] ARID,
   input  logic [3:0]  ARLEN,
   input  logic [1:0]  ARSIZE,
   input  logic [1:0]  ARBURST,
   output logic [63:0] RDATA,
   output logic [11:0] RID,
   output logic [1:0]  RRESP,
   output logic        RLAST,
   output logic        RVALID,
   input  logic        RREADY,
   output logic        mem_ren,
   output logic [31:0] mem_raddr,
   input  logic [63:0] mem_rdata
);

   localparam int unsigned PW = $clog2(QDEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);
   localparam logic [15:0]   LAT      = 16'(LATENCY);

   typedef enum logic {S_WAIT, S_BEAT} state_t;
   state_t state, state_nxt;

   logic [15:0]   now;

   // AR queue
   logic [31:0]   q_addr  [QDEPTH];
   logic [11:0]   q_id    [QDEPTH];
   logic [3:0]    q_len   [QDEPTH];
   logic [1:0]    q_size  [QDEPTH];
   logic [1:0]    q_burst [QDEPTH];
   logic [15:0]   q_ts    [QDEPTH];
   logic [PW-1:0] q_wr, q_rd;
   logic [CW-1:0] q_cnt;
   logic          push, pop;

   logic [31:0]   h_addr;
   logic [11:0]   h_id;
   logic [3:0]    h_len;
   logic [1:0]    h_size, h_burst;
   logic [15:0]   h_ts;
   logic          head_ok, head_err;

   // Burst walker
   logic [31:0]   cur, cur_nxt, wrap_mask;
   logic [3:0]    beat;
   logic          cur_err;
   logic          issue, last_beat, credit;

   // Response stage (tag for the beat whose data arrives this cycle)
   logic          st_vld, st_err, st_last;
   logic [11:0]   st_id;

   // 2-entry output FIFO
   logic [63:0]   f_data [2];
   logic [11:0]   f_id   [2];
   logic [1:0]    f_resp [2];
   logic          f_last [2];
   logic          f_wr, f_rd;
   logic [1:0]    f_occ;
   logic          r_pop;

   assign ARREADY = !reset && (q_cnt != FULL_CNT);
   assign push    = ARVALID && ARREADY;

   assign h_addr  = q_addr[q_rd];
   assign h_id    = q_id[q_rd];
   assign h_len   = q_len[q_rd];
   assign h_size  = q_size[q_rd];
   assign h_burst = q_burst[q_rd];
   assign h_ts    = q_ts[q_rd];

   assign RVALID  = (f_occ != 2'd0);
   assign RDATA   = f_data[f_rd];
   assign RID     = f_id[f_rd];
   assign RRESP   = f_resp[f_rd];
   assign RLAST   = f_last[f_rd];
   assign r_pop   = RVALID && RREADY;

   always_comb begin
      head_ok   = (q_cnt != '0) && ((now - h_ts) >= LAT);
      head_err  = (h_burst == 2'b11) || (h_size != 2'b11) ||
                  ((h_burst == 2'b10) && !(h_len inside {4'd1, 4'd3, 4'd7, 4'd15}));
      // WRAP boundary minus one: (len+1)*8 - 1
      wrap_mask = {25'd0, h_len, 3'b111};
      case (h_burst)
         2'b00:   cur_nxt = cur;
         2'b10:   cur_nxt = (cur & ~wrap_mask) | ((cur + 32'd8) & wrap_mask);
         default: cur_nxt = cur + 32'd8;
      endcase
   end

   // FSM: state register
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) state <= S_WAIT;
      else       state <= state_nxt;
   end

   // FSM: next state
   always_comb begin
      state_nxt = state;
      case (state)
         S_WAIT:  if (head_ok) state_nxt = S_BEAT;
         S_BEAT:  if (issue && last_beat) state_nxt = S_WAIT;
         default: state_nxt = S_WAIT;
      endcase
   end

   // FSM: outputs. Credit keeps FIFO occupancy plus the beat in the stage
   // register at or below 2 once the newly issued beat lands.
   always_comb begin
      credit    = ({1'b0, f_occ} + {2'b00, st_vld}) < (3'd2 + {2'b00, r_pop});
      issue     = (state == S_BEAT) && credit;
      last_beat = (beat == h_len);
      pop       = issue && last_beat;
      mem_ren   = issue && !cur_err;
      mem_raddr = cur;
   end

   // Queue storage (contents are only meaningful while counted)
   always_ff @(posedge CLK) begin
      if (push) begin
         q_addr[q_wr]  <= ARADDR;
         q_id[q_wr]    <= ARID;
         q_len[q_wr]   <= ARLEN;
         q_size[q_wr]  <= ARSIZE;
         q_burst[q_wr] <= ARBURST;
         q_ts[q_wr]    <= now;
      end
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         now     <= '0;
         q_wr    <= '0;
         q_rd    <= '0;
         q_cnt   <= '0;
         cur     <= '0;
         beat    <= '0;
         cur_err <= 1'b0;
         st_vld  <= 1'b0;
         st_err  <= 1'b0;
         st_last <= 1'b0;
         st_id   <= '0;
         f_wr    <= 1'b0;
         f_rd    <= 1'b0;
         f_occ   <= '0;
         for (int unsigned i = 0; i < 2; i++) begin
            f_data[i] <= '0;
            f_id[i]   <= '0;
            f_resp[i] <= '0;
            f_last[i] <= 1'b0;
         end
      end else begin
         now <= now + 16'd1;

         if (push) q_wr <= q_wr + PW'(1);
         if (pop)  q_rd <= q_rd + PW'(1);
         case ({push, pop})
            2'b10:   q_cnt <= q_cnt + CW'(1);
            2'b01:   q_cnt <= q_cnt - CW'(1);
            default: ;
         endcase

         if ((state == S_WAIT) && head_ok) begin
            cur     <= h_addr & ~32'h7;
            beat    <= '0;
            cur_err <= head_err;
         end else if (issue && !last_beat) begin
            cur  <= cur_nxt;
            beat <= beat + 4'd1;
         end

         st_vld  <= issue;
         st_err  <= cur_err;
         st_last <= last_beat;
         st_id   <= h_id;

         // Memory data is valid in the cycle after issue, aligned with the stage tag
         if (st_vld) begin
            f_data[f_wr] <= st_err ? '0 : mem_rdata;
            f_id[f_wr]   <= st_id;
            f_resp[f_wr] <= st_err ? 2'b10 : 2'b00;
            f_last[f_wr] <= st_last;
            f_wr         <= ~f_wr;
         end
         if (r_pop) f_rd <= ~f_rd;
         case ({st_vld, r_pop})
            2'b10:   f_occ <= f_occ + 2'd1;
            2'b01:   f_occ <= f_occ - 2'd1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_axi3_read_mem_responder.sv
// Testbench for axi3_read_mem_responder: directed and randomized AR traffic,
// expected R beats queued at AR acceptance, a negedge monitor pops and compares.
module tb_axi3_read_mem_responder;

   localparam int unsigned QD  = 4;
   localparam int unsigned LAT = 8;

   logic        CLK, reset;
   logic [31:0] ARADDR;
   logic        ARVALID, ARREADY;
   logic [11:0] ARID;
   logic [3:0]  ARLEN;
   logic [1:0]  ARSIZE, ARBURST;
   logic [63:0] RDATA;
   logic [11:0] RID;
   logic [1:0]  RRESP;
   logic        RLAST, RVALID, RREADY;
   logic        mem_ren;
   logic [31:0] mem_raddr;
   logic [63:0] mem_rdata;

   typedef struct packed {
      logic [63:0] data;
      logic [11:0] id;
      logic [1:0]  resp;
      logic        last;
   } beat_t;

   beat_t       exp_q[$];
   logic [31:0] rd_log[$];
   int          rd_cyc[$];
   int          hs_cyc[$];
   int          cyc = 0;
   int          n_checks = 0;
   int          n_pass = 0;
   int          rv_seen = 0;
   int          rr_mode = 0;
   int          acc_cyc = 0;

   axi3_read_mem_responder #(.QDEPTH(QD), .LATENCY(LAT)) dut (
      .CLK(CLK), .reset(reset),
      .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY), .ARID(ARID),
      .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
      .RDATA(RDATA), .RID(RID), .RRESP(RRESP), .RLAST(RLAST),
      .RVALID(RVALID), .RREADY(RREADY),
      .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial forever begin
      @(posedge CLK);
      cyc++;
   end

   function automatic logic [63:0] mem_word(input logic [31:0] a);
      return {a ^ 32'h5a5a_c3c3, ~a};
   endfunction

   // Memory with 1-cycle read latency; garbage when not strobed
   initial begin
      mem_rdata = '0;
      forever begin
         @(posedge CLK);
         if (mem_ren) mem_rdata <= mem_word(mem_raddr);
         else         mem_rdata <= {$urandom, $urandom};
      end
   end

   // RREADY patterns: 0 always, 1 one-in-three, 2 random, 3 never
   initial begin
      int ph = 0;
      RREADY = 1'b0;
      forever begin
         @(posedge CLK);
         #1;
         case (rr_mode)
            0: RREADY = 1'b1;
            1: begin ph = (ph + 1) % 3; RREADY = (ph == 0); end
            2: RREADY = 1'($urandom_range(0, 1));
            default: RREADY = 1'b0;
         endcase
      end
   end

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      $display("FAIL %s: event missing or unexpected (t=%0t)", name, $time);
   endtask

   // Reference: beat k's byte address from the burst rules
   function automatic logic [31:0] model_addr(input logic [31:0] a, input logic [1:0] burst,
                                              input int unsigned len, input int unsigned k);
      logic [31:0] base, lo;
      int unsigned w;
      base = a & 32'hffff_fff8;
      case (burst)
         2'b00: return base;
         2'b10: begin
            w  = (len + 1) * 8;
            lo = base - (base % w);
            return lo + ((base - lo + 8 * k) % w);
         end
         default: return base + 8 * k;
      endcase
   endfunction

   task automatic push_expected(input logic [31:0] addr, input logic [11:0] id, input logic [3:0] len,
                                input logic [1:0] size, input logic [1:0] burst);
      beat_t b;
      int unsigned l;
      bit err;
      l   = len;
      err = (burst == 2'b11) || (size != 2'b11) ||
            (burst == 2'b10 && !(l == 1 || l == 3 || l == 7 || l == 15));
      for (int unsigned k = 0; k <= l; k++) begin
         b.data = err ? 64'h0 : mem_word(model_addr(addr, burst, l, k));
         b.id   = id;
         b.resp = err ? 2'b10 : 2'b00;
         b.last = (k == l);
         exp_q.push_back(b);
      end
   endtask

   // Call at posedge+1; returns at posedge+1 after the accepting edge
   task automatic send_ar(input logic [31:0] addr, input logic [11:0] id, input logic [3:0] len,
                          input logic [1:0] size, input logic [1:0] burst);
      bit acc = 1'b0;
      ARADDR = addr; ARID = id; ARLEN = len; ARSIZE = size; ARBURST = burst;
      ARVALID = 1'b1;
      for (int unsigned i = 0; i < 500 && !acc; i++) begin
         @(negedge CLK);
         acc = ARREADY;
      end
      if (acc) begin
         acc_cyc = cyc;
         push_expected(addr, id, len, size, burst);
      end else fail_now("ar_accept_timeout");
      @(posedge CLK);
      #1;
      ARVALID = 1'b0;
   endtask

   task automatic wait_drain(input int unsigned bound);
      int unsigned n = 0;
      while (exp_q.size() != 0 && n < bound) begin
         @(negedge CLK);
         n++;
      end
      if (exp_q.size() != 0) begin
         fail_now("drain_timeout");
         exp_q.delete();
      end
      repeat (3) @(posedge CLK);
      #1;
   endtask

   task automatic clear_logs();
      rd_log.delete();
      rd_cyc.delete();
      hs_cyc.delete();
   endtask

   task automatic chk_raddr(input string name, input int unsigned idx, input logic [31:0] exp);
      if (idx >= rd_log.size()) fail_now(name);
      else chk(name, rd_log[idx], exp);
   endtask

   // Monitor: scoreboard, output stability while stalled, read address alignment
   initial begin
      bit          stall_prev = 1'b0;
      logic [78:0] held = '0;
      beat_t       e;
      forever begin
         @(negedge CLK);
         if (reset) stall_prev = 1'b0;
         else begin
            if (stall_prev) begin
               chk("r_hold_valid", RVALID, 1);
               chk("r_hold_beat", {RDATA, RID, RRESP, RLAST}, held);
            end
            if (mem_ren) begin
               rd_log.push_back(mem_raddr);
               rd_cyc.push_back(cyc);
               chk("raddr_align", mem_raddr[2:0], 0);
            end
            if (RVALID) rv_seen++;
            if (RVALID && RREADY) begin
               hs_cyc.push_back(cyc);
               if (exp_q.size() == 0) fail_now("unexpected_beat");
               else begin
                  e = exp_q.pop_front();
                  chk("rdata", RDATA, e.data);
                  chk("rid", RID, e.id);
                  chk("rresp", RRESP, e.resp);
                  chk("rlast", RLAST, e.last);
               end
            end
            stall_prev = RVALID && !RREADY;
            held       = {RDATA, RID, RRESP, RLAST};
         end
      end
   end

   initial begin
      #400000;
      fail_now("global_timeout");
      $fatal(1, "simulation time limit reached");
   end

   initial begin
      int a;
      int base;
      bit seen;
      logic [31:0] addr;
      logic [11:0] id;
      logic [3:0]  len;
      logic [1:0]  size, burst;
      int unsigned gap;

      reset = 1'b1; ARVALID = 1'b0; ARADDR = '0; ARID = '0; ARLEN = '0;
      ARSIZE = 2'b11; ARBURST = 2'b01; rr_mode = 0;
      repeat (2) @(negedge CLK);
      chk("rst_arready", ARREADY, 0);
      chk("rst_rvalid", RVALID, 0);
      chk("rst_rlast", RLAST, 0);
      chk("rst_mem_ren", mem_ren, 0);
      chk("rst_rdata", RDATA, 0);
      chk("rst_rid", RID, 0);
      chk("rst_rresp", RRESP, 0);
      chk("rst_mem_raddr", mem_raddr, 0);
      @(posedge CLK); #1;
      reset = 1'b0;
      @(negedge CLK);
      chk("arready_after_reset", ARREADY, 1);
      @(posedge CLK); #1;

      // Single beat: latency to mem_ren and RVALID
      clear_logs();
      send_ar(32'h0000_1003, 12'h005, 4'd0, 2'b11, 2'b01);
      a = acc_cyc;
      wait_drain(200);
      chk_raddr("single_raddr", 0, 32'h0000_1000);
      if (rd_cyc.size() == 0) fail_now("single_ren_seen");
      else chk("single_ren_cycle", rd_cyc[0] - a, LAT + 1);
      if (hs_cyc.size() == 0) fail_now("single_rvalid_seen");
      else chk("single_rvalid_cycle", hs_cyc[0] - a, LAT + 3);

      // INCR burst, full throughput
      clear_logs();
      send_ar(32'h0000_2000, 12'h1a7, 4'd3, 2'b11, 2'b01);
      wait_drain(200);
      chk_raddr("incr_raddr0", 0, 32'h0000_2000);
      chk_raddr("incr_raddr1", 1, 32'h0000_2008);
      chk_raddr("incr_raddr2", 2, 32'h0000_2010);
      chk_raddr("incr_raddr3", 3, 32'h0000_2018);
      if (rd_cyc.size() == 4 && hs_cyc.size() == 4) begin
         chk("incr_ren_back_to_back", rd_cyc[3] - rd_cyc[0], 3);
         chk("incr_r_back_to_back", hs_cyc[3] - hs_cyc[0], 3);
      end else fail_now("incr_beat_count");

      // WRAP burst
      clear_logs();
      send_ar(32'h0000_2010, 12'h2b1, 4'd3, 2'b11, 2'b10);
      wait_drain(200);
      chk_raddr("wrap_raddr0", 0, 32'h0000_2010);
      chk_raddr("wrap_raddr1", 1, 32'h0000_2018);
      chk_raddr("wrap_raddr2", 2, 32'h0000_2000);
      chk_raddr("wrap_raddr3", 3, 32'h0000_2008);

      // Backpressure: 16 beats, RREADY one cycle in three
      rr_mode = 1;
      clear_logs();
      send_ar(32'h0000_3000, 12'h0c3, 4'd15, 2'b11, 2'b01);
      wait_drain(500);
      chk("bp_ren_count", rd_log.size(), 16);
      chk("bp_beat_count", hs_cyc.size(), 16);
      for (int unsigned k = 0; k < 16; k++) chk_raddr("bp_raddr", k, 32'h0000_3000 + 32'(8 * k));

      // Error bursts: reserved burst, bad size, illegal WRAP length
      rr_mode = 0;
      clear_logs();
      send_ar(32'h0000_4000, 12'h301, 4'd1, 2'b11, 2'b11);
      send_ar(32'h0000_4100, 12'h302, 4'd0, 2'b10, 2'b01);
      send_ar(32'h0000_4200, 12'h303, 4'd2, 2'b11, 2'b10);
      wait_drain(300);
      chk("err_no_mem_ren", rd_log.size(), 0);
      chk("err_beat_count", hs_cyc.size(), 6);

      // Queue full with RREADY held low
      rr_mode = 3;
      repeat (2) @(posedge CLK); #1;
      clear_logs();
      for (int unsigned i = 0; i < 4; i++)
         send_ar(32'h0000_6000 + 32'(i * 64), 12'(16'h600 + i), 4'd0, 2'b11, 2'b01);
      @(negedge CLK);
      chk("full_arready_low", ARREADY, 0);
      @(posedge CLK); #1;
      send_ar(32'h0000_6100, 12'h605, 4'd0, 2'b11, 2'b01);
      if (rd_cyc.size() == 0) fail_now("full_first_issue");
      else chk("full_reaccept_cycle", acc_cyc - rd_cyc[0], 1);
      rr_mode = 0;
      wait_drain(300);

      // Randomized traffic
      rr_mode = 2;
      for (int unsigned n = 0; n < 40; n++) begin
         burst = 2'($urandom_range(0, 3));
         size  = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
         len   = 4'($urandom_range(0, 15));
         if (burst == 2'b10 && $urandom_range(0, 3) != 0) len = 4'((1 << $urandom_range(1, 4)) - 1);
         addr  = $urandom;
         id    = 12'($urandom);
         send_ar(addr, id, len, size, burst);
         gap = $urandom_range(0, 3);
         if (gap != 0) begin
            repeat (gap) @(posedge CLK);
            #1;
         end
      end
      wait_drain(3000);

      // Reset in the middle of a burst
      rr_mode = 1;
      repeat (2) @(posedge CLK); #1;
      clear_logs();
      send_ar(32'h0000_7000, 12'h7aa, 4'd15, 2'b11, 2'b01);
      seen = 1'b0;
      for (int unsigned i = 0; i < 200 && !seen; i++) begin
         @(negedge CLK);
         seen = (hs_cyc.size() >= 2);
      end
      if (!seen) fail_now("midrst_beats_started");
      @(negedge CLK); #2;
      reset = 1'b1;
      #1;
      chk("midrst_rvalid", RVALID, 0);
      chk("midrst_arready", ARREADY, 0);
      chk("midrst_mem_ren", mem_ren, 0);
      exp_q.delete();
      repeat (2) @(posedge CLK);
      #1;
      reset = 1'b0;
      base = rv_seen;
      @(negedge CLK);
      chk("midrst_arready_after", ARREADY, 1);
      repeat (40) @(negedge CLK);
      chk("midrst_no_beats", rv_seen - base, 0);

      // Normal operation after reset
      @(posedge CLK); #1;
      rr_mode = 0;
      repeat (2) @(posedge CLK); #1;
      send_ar(32'h0000_8008, 12'h8bc, 4'd1, 2'b11, 2'b01);
      wait_drain(200);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/axi3_read_mem_responder.md
# axi3_read_mem_responder

Simulation-side AXI3 read slave that sits directly downstream of the `MAXI0`/`MAXI1` read master ports of the Verilator SoC wrapper. It consumes AR requests and returns R bursts sourced from a 1-cycle-latency memory read port driven by the C++ harness. Requests are queued, delayed by a programmable DRAM-like latency, and then replayed beat by beat under RREADY backpressure.

## Interface
- `QDEPTH`, 4: AR queue depth; power of 2, ≥2.
- `LATENCY`, 8: minimum cycles from AR acceptance to head-entry eligibility; range 1..32767.
- `CLK`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high reset.
- `ARADDR`  in  32  burst start byte address.
- `ARVALID`  in  1  request valid.
- `ARREADY`  out  1  request accepted on `ARVALID & ARREADY`.
- `ARID`  in  12  transaction ID.
- `ARLEN`  in  4  beats − 1.
- `ARSIZE`  in  2  beat size; only 2'b11 (8 B) is legal.
- `ARBURST`  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- `RDATA`  out  64  beat data.
- `RID`  out  12  echoes ARID.
- `RRESP`  out  2  00 OKAY, 10 SLVERR.
- `RLAST`  out  1  final beat of burst.
- `RVALID`  out  1  beat valid.
- `RREADY`  in  1  beat consumed on `RVALID & RREADY`.
- `mem_ren`  out  1  memory read strobe.
- `mem_raddr`  out  32  8-byte-aligned read address; `[2:0]` is always 0.
- `mem_rdata`  in  64  data for the `mem_ren` of the previous cycle.

## Operation
- **Cycle counter.** Free-running 16-bit counter `now`, wraps.
- **AR queue.** FIFO of QDEPTH entries holding {addr, id, len, size, burst, ts}, with `ts = now` at acceptance.
  - `ARREADY = (count != QDEPTH)`; it depends on count only.
  - A full queue does not accept in the same cycle as a pop.
- **Eligibility.** The head entry is eligible when `(now - ts) mod 2^16 >= LATENCY`.
- **Error detection.** A burst is an error when any of these holds:
  - `ARBURST == 11`;
  - `ARSIZE != 11`;
  - WRAP with `ARLEN` not in {1, 3, 7, 15}.
- **FSM states: WAIT, BEAT.**
  - WAIT: when the queue is non-empty and the head is eligible, load `cur = {ARADDR[31:3], 3'b0}`, set `beat = 0`, capture the error flag, go to BEAT.
  - BEAT: each cycle with credit, issue one beat:
    - OK beat: `mem_ren = 1`, `mem_raddr = cur`.
    - Error beat: `mem_ren = 0`, and a {data 0, SLVERR} beat enters the pipeline instead.
  - After issuing beat `len`: pop the queue, return to WAIT.
- **Address update per beat.**
  - FIXED: `cur` unchanged.
  - INCR: `cur += 8`, wrapping mod 2^32.
  - WRAP: boundary size `W = (len+1)*8`; `cur = (cur & ~(W-1)) | ((cur + 8) & (W-1))`.
- **Response pipeline.** Stage register (1 cycle), then a 2-entry output FIFO of {data, id, resp, last}.
  - `mem_rdata` is written with the stage tag at the end of the cycle after issue.
  - `RLAST = 1` on beat `len` only.
- **Credit rule.** Issue a beat only if `occupancy + inflight − pop < 2`.
  - `inflight` = a beat issued in the previous cycle.
  - `pop` = `RVALID & RREADY` this cycle.
  - The FIFO never overflows.
- **Output stability.** `RVALID` = FIFO non-empty. RDATA/RID/RRESP/RLAST are held stable while `RVALID & !RREADY`.

## Timing
- **Reset values** (asynchronous assert; effect visible on the next edge after deassert):
  - `RVALID`, `RLAST`, `mem_ren` = 0;
  - `RDATA`, `RID`, `RRESP`, `mem_raddr` = 0;
  - queue empty, FSM = WAIT, `now = 0`.
- **ARREADY under reset.** `ARREADY = 0` while `reset` is high; `ARREADY = 1` from the first cycle after reset deasserts.
- **First-beat latency.** With the block idle, AR accepted in cycle `a`:
  - head eligible in cycle `a + LATENCY`;
  - first `mem_ren` in `a + LATENCY + 1`;
  - first `RVALID` in `a + LATENCY + 3`.
- **Throughput.** With RREADY held at 1, one beat per cycle and no bubbles within a burst. There is one idle cycle between bursts (the WAIT state).
- **Reset mid-burst.** Queued requests, in-flight beats and FIFO contents are discarded. No partial beat appears after reset.
- **Beat ordering.** Beats of burst N+1 never precede the RLAST of burst N. Responses are returned in order, regardless of ID.

## Test plan
- **Single beat.** LATENCY=8; INCR, ARADDR=0x1003, ARLEN=0, ARID=0x05, accepted at cycle 10 -> `mem_raddr = 0x1000` in cycle 19; RVALID in cycle 21 with RDATA = mem[0x1000], RID = 0x05, RRESP = 00, RLAST = 1.
- **INCR burst.** ARADDR=0x2000, ARLEN=3, RREADY=1 -> `mem_raddr` 0x2000, 0x2008, 0x2010, 0x2018 on consecutive cycles; 4 consecutive R beats; RLAST only on the 4th.
- **WRAP burst.** ARADDR=0x2010, ARLEN=3, ARBURST=10 -> `mem_raddr` 0x2010, 0x2018, 0x2000, 0x2008.
- **Backpressure.** ARLEN=15 with RREADY high 1 cycle in 3 -> all 16 beats delivered in address order; R outputs stable while stalled; FIFO never exceeds 2 entries.
- **Queue full.** QDEPTH=4, RREADY=0, 5 back-to-back ARs -> ARREADY=0 after the 4th acceptance; it returns to 1 the cycle after the first burst pops; the 5th request is then accepted.
- **Errors and reset.**
  - ARBURST=11, ARLEN=1 -> 2 beats with RRESP=10 and RDATA=0, no `mem_ren`.
  - ARSIZE=10 -> SLVERR.
  - `reset` pulsed mid-burst -> RVALID=0 immediately; no further beats.
